// File: rtl/prf_debug_ctrl.sv
// prf_debug_ctrl: byte-wide debug access port onto the 64-bit physical register file.
// The debug side moves one byte per request; word traffic to the PRF is only issued
// when the writeback lanes are free (prfIdle_i), so the core's write ports are never contended.
// Optional feature macro PRF_DEBUG_HOLD_EN: when defined, a stall counter asks the core to
// hold writebacks after HOLD_THRESH consecutive busy cycles; when undefined, coreHold_o is 0.

`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 64
`endif

module prf_debug_ctrl #(
  parameter int unsigned HOLD_THRESH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  // Debug byte interface
  input  logic                            dbgReq_i,
  input  logic                            dbgWr_i,
  input  logic [`SIZE_PHYSICAL_LOG+3-1:0] dbgAddr_i,
  input  logic [7:0]                      dbgWrData_i,
  output logic                            dbgAck_o,
  output logic [7:0]                      dbgRdData_o,
  // Core / PRF side
  input  logic                            prfIdle_i,
  output logic                            coreHold_o,
  output logic [`SIZE_PHYSICAL_LOG-1:0]   prfAddr_o,
  output logic                            prfWrEn_o,
  output logic [`SIZE_DATA-1:0]           prfWrData_o,
  output logic                            prfRdEn_o,
  input  logic [`SIZE_DATA-1:0]           prfRdData_i
);

  localparam int unsigned PhysLog = `SIZE_PHYSICAL_LOG;
  localparam int unsigned DataW   = `SIZE_DATA;

  typedef enum logic [2:0] {
    StIdle,
    StWaitWr,
    StWaitRd,
    StRdData,
    StAck
  } state_e;

  state_e               state_q, state_d;
  logic [DataW-1:0]     wr_buf_q, wr_buf_d;   // write-assembly buffer
  logic [DataW-1:0]     rd_buf_q, rd_buf_d;   // last word read from the PRF
  logic [PhysLog-1:0]   idx_q, idx_d;         // latched PRF register index
  logic [7:0]           rd_data_q, rd_data_d; // byte returned to the debug side

  logic [2:0]           req_lane;
  logic [PhysLog-1:0]   req_idx;
  logic                 waiting;

  assign req_lane = dbgAddr_i[2:0];
  assign req_idx  = dbgAddr_i[PhysLog+2:3];
  assign waiting  = (state_q == StWaitWr) || (state_q == StWaitRd);

  // Next-state and datapath updates for the access sequencer
  always_comb begin
    state_d   = state_q;
    wr_buf_d  = wr_buf_q;
    rd_buf_d  = rd_buf_q;
    idx_d     = idx_q;
    rd_data_d = rd_data_q;
    case (state_q)
      StIdle: begin
        if (dbgReq_i) begin
          if (dbgWr_i) begin
            wr_buf_d[{req_lane, 3'b000} +: 8] = dbgWrData_i;
            // Lane 7 completes the word and commits it to the PRF
            if (req_lane == 3'd7) begin
              idx_d   = req_idx;
              state_d = StWaitWr;
            end else begin
              state_d = StAck;
            end
          end else if (req_lane == 3'd0) begin
            // Lane 0 fetches a fresh word; other lanes are served from the read buffer
            idx_d   = req_idx;
            state_d = StWaitRd;
          end else begin
            rd_data_d = rd_buf_q[{req_lane, 3'b000} +: 8];
            state_d   = StAck;
          end
        end
      end
      StWaitWr: begin
        if (prfIdle_i) begin
          state_d = StAck;
        end
      end
      StWaitRd: begin
        if (prfIdle_i) begin
          state_d = StRdData;
        end
      end
      StRdData: begin
        rd_buf_d  = prfRdData_i;
        rd_data_d = prfRdData_i[7:0];
        state_d   = StAck;
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      wr_buf_q  <= '0;
      rd_buf_q  <= '0;
      idx_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_buf_q  <= wr_buf_d;
      rd_buf_q  <= rd_buf_d;
      idx_q     <= idx_d;
      rd_data_q <= rd_data_d;
    end
  end

  // PRF strobes are gated by prfIdle_i so they can only fire when the write ports are free
  assign prfWrEn_o   = (state_q == StWaitWr) && prfIdle_i;
  assign prfRdEn_o   = (state_q == StWaitRd) && prfIdle_i;
  assign prfWrData_o = wr_buf_q;
  assign prfAddr_o   = idx_q;
  assign dbgAck_o    = (state_q == StAck);
  assign dbgRdData_o = rd_data_q;

`ifdef PRF_DEBUG_HOLD_EN
  localparam int unsigned CntW = $clog2(HOLD_THRESH) + 1;
  localparam logic [CntW-1:0] HoldMax = CntW'(HOLD_THRESH);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count busy cycles spent waiting; saturate at the threshold, clear when the wait ends
  always_comb begin
    cnt_d = cnt_q;
    if (waiting) begin
      if (prfIdle_i) begin
        cnt_d = '0;
      end else if (cnt_q != HoldMax) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Wait counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Hold stays up through the issue cycle because the counter clears only afterwards
  assign coreHold_o = waiting && (cnt_q == HoldMax);
`else
  assign coreHold_o = 1'b0;
`endif

endmodule

// File: tb/tb_prf_debug_ctrl.sv
// Directed, table-driven bench for prf_debug_ctrl plus hand sequences for held requests,
// long waits (hold behaviour when PRF_DEBUG_HOLD_EN is defined) and reset mid-access.

`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 64
`endif

module tb_prf_debug_ctrl;

  localparam int PL = `SIZE_PHYSICAL_LOG;
  localparam int AW = PL + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          dbgReq_i;
  logic          dbgWr_i;
  logic [AW-1:0] dbgAddr_i;
  logic [7:0]    dbgWrData_i;
  logic          dbgAck_o;
  logic [7:0]    dbgRdData_o;
  logic          prfIdle_i;
  logic          coreHold_o;
  logic [PL-1:0] prfAddr_o;
  logic          prfWrEn_o;
  logic [63:0]   prfWrData_o;
  logic          prfRdEn_o;
  logic [63:0]   prfRdData_i;

  always #5 clk = ~clk;

  prf_debug_ctrl #(.HOLD_THRESH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .dbgReq_i    (dbgReq_i),
    .dbgWr_i     (dbgWr_i),
    .dbgAddr_i   (dbgAddr_i),
    .dbgWrData_i (dbgWrData_i),
    .dbgAck_o    (dbgAck_o),
    .dbgRdData_o (dbgRdData_o),
    .prfIdle_i   (prfIdle_i),
    .coreHold_o  (coreHold_o),
    .prfAddr_o   (prfAddr_o),
    .prfWrEn_o   (prfWrEn_o),
    .prfWrData_o (prfWrData_o),
    .prfRdEn_o   (prfRdEn_o),
    .prfRdData_i (prfRdData_i)
  );

  typedef struct {
    logic        wr;
    int          reg_idx;
    int          lane;
    logic [7:0]  wd;
    int          idle_low;
    logic [63:0] rdword;
    int          exp_lat;
    logic [7:0]  exp_rd;
    int          exp_nwr;
    int          exp_nrd;
    logic [63:0] exp_word;
    int          exp_addr;
  } vec_t;

  localparam int NVec = 26;
  localparam int NPre = 23;
  vec_t vecs[NVec];

  int checks = 0;
  int errors = 0;

  // Results of the last access
  int          r_lat, r_nwr, r_nrd, r_viol, r_hold_first, r_hold_cnt, r_nack;
  logic [7:0]  r_rd;
  logic [63:0] r_word;
  logic [PL-1:0] r_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] mk_addr(input int r, input int l);
    logic [AW-1:0] a;
    a = '0;
    a[2:0] = l[2:0];
    a[AW-1:3] = r[PL-1:0];
    return a;
  endfunction

  // Issue one request in cycle 0; prfIdle_i low in cycles 1..idle_low; keep dbgReq_i high
  // for hold_extra cycles past the first ack. Entered and left #1 after a rising edge.
  task automatic run_access(input logic wr, input logic [AW-1:0] addr, input logic [7:0] wd,
                            input int idle_low, input int hold_extra);
    int k;
    int low_cnt;
    bit done;
    r_lat = -1; r_nwr = 0; r_nrd = 0; r_viol = 0; r_hold_first = -1; r_hold_cnt = 0;
    r_nack = 0; r_rd = '0; r_word = '0; r_addr = '0;
    k = 0; low_cnt = 0; done = 1'b0;
    dbgReq_i = 1'b1; dbgWr_i = wr; dbgAddr_i = addr; dbgWrData_i = wd; prfIdle_i = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (prfWrEn_o && prfRdEn_o) r_viol++;
      if (!prfIdle_i && (prfWrEn_o || prfRdEn_o)) r_viol++;
      if (prfWrEn_o) begin r_nwr++; r_word = prfWrData_o; r_addr = prfAddr_o; end
      if (prfRdEn_o) begin r_nrd++; r_addr = prfAddr_o; end
      if (coreHold_o) begin
        r_hold_cnt++;
        if (r_hold_first < 0) r_hold_first = k;
      end
      if (dbgAck_o) begin
        r_nack++;
        if (r_lat < 0) begin r_lat = k; r_rd = dbgRdData_o; end
      end
      @(posedge clk); #1;
      k++;
      if (r_lat >= 0 && k > r_lat + hold_extra) begin
        dbgReq_i = 1'b0;
        low_cnt++;
      end
      if (low_cnt > 2 || k > 200) done = 1'b1;
      prfIdle_i = !(k >= 1 && k <= idle_low);
    end
    dbgReq_i = 1'b0;
    prfIdle_i = 1'b1;
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    v = vecs[i];
    prfRdData_i = v.rdword;
    run_access(v.wr, mk_addr(v.reg_idx, v.lane), v.wd, v.idle_low, 0);
    check($sformatf("v%0d_latency", i), 64'(r_lat), 64'(v.exp_lat));
    if (!v.wr) check($sformatf("v%0d_rddata", i), 64'(r_rd), 64'(v.exp_rd));
    check($sformatf("v%0d_nwr", i), 64'(r_nwr), 64'(v.exp_nwr));
    check($sformatf("v%0d_nrd", i), 64'(r_nrd), 64'(v.exp_nrd));
    check($sformatf("v%0d_nack", i), 64'(r_nack), 64'd1);
    check($sformatf("v%0d_strobe_rules", i), 64'(r_viol), 64'd0);
    check($sformatf("v%0d_hold", i), 64'(r_hold_cnt), 64'd0);
    if (v.exp_nwr != 0) check($sformatf("v%0d_wrword", i), r_word, v.exp_word);
    if (v.exp_nwr != 0 || v.exp_nrd != 0)
      check($sformatf("v%0d_addr", i), 64'(r_addr), 64'(v.exp_addr));
  endtask

  initial begin
    int nbad;
    logic [7:0] b;

    // Reg 5 byte writes 0x11..0x88, then reads of the same word
    for (int l = 0; l < 8; l++) begin
      b = 8'((l + 1) * 17);
      vecs[l] = '{1'b1, 5, l, b, 0, 64'h0, (l == 7) ? 2 : 1, 8'h00,
                  (l == 7) ? 1 : 0, 0, 64'h8877665544332211, 5};
      vecs[8 + l] = '{1'b0, 5, l, 8'h00, 0, 64'h8877665544332211, (l == 0) ? 3 : 1, b,
                      0, (l == 0) ? 1 : 0, 64'h0, 5};
    end
    vecs[16] = '{1'b1, 9, 7, 8'hAB, 5, 64'h0, 7, 8'h00, 1, 0, 64'hAB77665544332211, 9};
    vecs[17] = '{1'b1, 0, 2, 8'h5A, 0, 64'h0, 1, 8'h00, 0, 0, 64'h0, 0};
    vecs[18] = '{1'b1, 3, 7, 8'hC3, 2, 64'h0, 4, 8'h00, 1, 0, 64'hC3776655445A2211, 3};
    vecs[19] = '{1'b0, 3, 0, 8'h00, 3, 64'h0102030405060708, 6, 8'h08, 0, 1, 64'h0, 3};
    vecs[20] = '{1'b0, 3, 5, 8'h00, 0, 64'h0, 1, 8'h03, 0, 0, 64'h0, 3};
    vecs[21] = '{1'b1, 7, 7, 8'h01, 0, 64'h0, 2, 8'h00, 1, 0, 64'h01776655445A2211, 7};
    vecs[22] = '{1'b0, 7, 6, 8'h00, 0, 64'h0, 1, 8'h02, 0, 0, 64'h0, 7};
    // After the mid-access reset: buffers cleared, normal service
    vecs[23] = '{1'b0, 0, 3, 8'h00, 0, 64'h0, 1, 8'h00, 0, 0, 64'h0, 0};
    vecs[24] = '{1'b1, 2, 7, 8'hFF, 0, 64'h0, 2, 8'h00, 1, 0, 64'hFF00000000000000, 2};
    vecs[25] = '{1'b0, 2, 0, 8'h00, 0, 64'h1122334455667788, 3, 8'h88, 0, 1, 64'h0, 2};

    reset = 1'b0; dbgReq_i = 1'b0; dbgWr_i = 1'b0; dbgAddr_i = '0; dbgWrData_i = '0;
    prfIdle_i = 1'b1; prfRdData_i = '0;
    #2;
    check("rst_ack", 64'(dbgAck_o), 64'd0);
    check("rst_rddata", 64'(dbgRdData_o), 64'd0);
    check("rst_hold", 64'(coreHold_o), 64'd0);
    check("rst_addr", 64'(prfAddr_o), 64'd0);
    check("rst_wren", 64'(prfWrEn_o), 64'd0);
    check("rst_rden", 64'(prfRdEn_o), 64'd0);
    check("rst_wrdata", prfWrData_o, 64'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) apply_vec(i);
    check("addr_before_first_latch", 64'(prfAddr_o), 64'd0);
    for (int i = 7; i < NPre; i++) apply_vec(i);

    // Request held high past the ack is taken as a second request
    run_access(1'b0, mk_addr(7, 1), 8'h00, 0, 2);
    check("held_req_latency", 64'(r_lat), 64'd1);
    check("held_req_rddata", 64'(r_rd), 64'h07);
    check("held_req_nack", 64'(r_nack), 64'd2);

    // Long wait: 30 busy cycles before the lane-7 write can issue
    run_access(1'b1, mk_addr(1, 7), 8'h99, 30, 0);
    check("long_latency", 64'(r_lat), 64'd32);
    check("long_nwr", 64'(r_nwr), 64'd1);
    check("long_word", r_word, 64'h99776655445A2211);
    check("long_strobe_rules", 64'(r_viol), 64'd0);
`ifdef PRF_DEBUG_HOLD_EN
    check("long_hold_first", 64'(r_hold_first), 64'd17);
    check("long_hold_cycles", 64'(r_hold_cnt), 64'd15);
`else
    check("long_hold_cycles", 64'(r_hold_cnt), 64'd0);
`endif

    // Reset while waiting for a read slot
    dbgReq_i = 1'b1; dbgWr_i = 1'b0; dbgAddr_i = mk_addr(4, 0); prfIdle_i = 1'b1;
    @(posedge clk); #1;
    prfIdle_i = 1'b0; dbgReq_i = 1'b0;
    @(posedge clk); #2;
    check("pre_rst_addr", 64'(prfAddr_o), 64'd4);
    reset = 1'b0;
    #1;
    check("mid_rst_ack", 64'(dbgAck_o), 64'd0);
    check("mid_rst_rden", 64'(prfRdEn_o), 64'd0);
    check("mid_rst_addr", 64'(prfAddr_o), 64'd0);
    check("mid_rst_rddata", 64'(dbgRdData_o), 64'd0);
    check("mid_rst_wrdata", prfWrData_o, 64'd0);
    nbad = 0;
    prfIdle_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (prfRdEn_o || prfWrEn_o || dbgAck_o) nbad++;
      @(posedge clk);
    end
    #2 reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (prfRdEn_o || prfWrEn_o || dbgAck_o) nbad++;
      @(posedge clk); #1;
    end
    check("aborted_read_quiet", 64'(nbad), 64'd0);

    for (int i = NPre; i < NVec; i++) apply_vec(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prf_debug_ctrl.md
PRF_DEBUG_CTRL -- requirements
Module: prf_debug_ctrl

Interface
REQ-001 SHALL have parameter HOLD_THRESH, default 16, meaning the number of consecutive not-idle wait cycles before a core hold is requested.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port dbgReq_i  input  1  level request from the off-chip debug interface.
REQ-005 SHALL have port dbgWr_i  input  1  1=byte write, 0=byte read; sampled with dbgReq_i.
REQ-006 SHALL have port dbgAddr_i  input  `SIZE_PHYSICAL_LOG+3  bits [2:0]=byte lane, upper bits=physical register index.
REQ-007 SHALL have port dbgWrData_i  input  8  write byte.
REQ-008 SHALL have port dbgAck_o  output  1  one-cycle completion pulse.
REQ-009 SHALL have port dbgRdData_o  output  8  read byte; valid in the dbgAck_o cycle.
REQ-010 SHALL have port prfIdle_i  input  1  no writeback lane valid this cycle (PRF write ports free).
REQ-011 SHALL have port coreHold_o  output  1  request to the core to stop issuing writebacks.
REQ-012 SHALL have port prfAddr_o  output  `SIZE_PHYSICAL_LOG  PRF word address.
REQ-013 SHALL have ports prfWrEn_o (output 1), prfWrData_o (output `SIZE_DATA=64): PRF word write.
REQ-014 SHALL have ports prfRdEn_o (output 1), prfRdData_i (input 64): PRF word read; data valid the cycle after prfRdEn_o.

Function
REQ-015 SHALL implement states IDLE, WAIT_WR, WAIT_RD, RD_DATA, ACK.
REQ-016 In IDLE with dbgReq_i=1: write to lane 0-6 -> store byte into 64-bit write-assembly buffer at lane, go ACK (ack at T+1).
REQ-017 Write to lane 7 -> store byte, latch register index, go WAIT_WR.
REQ-018 Read from lane 0 -> latch register index, go WAIT_RD; read from lane 1-7 -> go ACK, return that lane of the read buffer (ack at T+1).
REQ-019 WAIT_WR: when prfIdle_i=1, drive prfWrEn_o=1 for exactly that cycle with latched index and full assembly buffer (lane 7 included), go ACK.
REQ-020 WAIT_RD: when prfIdle_i=1, drive prfRdEn_o=1 for that cycle, go RD_DATA; RD_DATA captures prfRdData_i into read buffer, go ACK returning lane 0.
REQ-021 Minimum latencies: lane-7 write ack T+2; lane-0 read ack T+3; prfIdle_i=0 cycles add one each.
REQ-022 ACK: dbgAck_o=1 for one cycle, then IDLE; dbgRdData_o holds its value outside ACK; a dbgReq_i still high in the first IDLE cycle is a new request.
REQ-023 prfWrEn_o and prfRdEn_o SHALL never both be 1, and SHALL be 0 whenever prfIdle_i=0.
REQ-024 Assembly buffer is not cleared after a word write; unwritten lanes keep prior values; read buffer is not invalidated by PRF writes.
REQ-025 Wait counter: width $clog2(HOLD_THRESH)+1, increments each WAIT_* cycle with prfIdle_i=0, saturates, clears on leaving WAIT_*.
REQ-026 prfAddr_o SHALL equal the latched index; it is 0 after reset until the first latch.

Reset
REQ-027 reset=0 SHALL asynchronously force IDLE, both buffers, latched index, counter, and all outputs to 0.
REQ-028 Reset mid-access SHALL abort it: no prfWrEn_o/prfRdEn_o and no dbgAck_o for the aborted request.

Configuration
REQ-029 Macro PRF_DEBUG_HOLD_EN defined: coreHold_o=1 from the cycle after the counter reaches HOLD_THRESH until the cycle the PRF access is issued, inclusive.
REQ-030 PRF_DEBUG_HOLD_EN undefined: no counter, coreHold_o tied 0, WAIT_* waits indefinitely.

Verification
REQ-031 Writes 0x11..0x88 to lanes 0-7 of reg 5, prfIdle_i=1 -> one prfWrEn_o, prfAddr_o=5, prfWrData_o=0x8877665544332211, eight acks.
REQ-032 Read reg 5 lanes 0-7 after REQ-031, prfRdData_i=0x8877665544332211 -> one prfRdEn_o, dbgRdData_o 0x11..0x88, lane-0 ack at T+3.
REQ-033 Lane-7 write with prfIdle_i=0 for 5 cycles -> prfWrEn_o in the first idle cycle, ack T+7, coreHold_o=0.
REQ-034 PRF_DEBUG_HOLD_EN, HOLD_THRESH=16, prfIdle_i=0 for 30 cycles -> coreHold_o rises after 16 wait cycles, falls after the write issues.
REQ-035 reset=0 in WAIT_RD -> outputs 0 immediately, no prfRdEn_o, no ack; next request served normally.
